// File: rtl/stb_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stb_cmd_pkg
// Brief    : Shared types for the STB command queue (command record, FSM states).
// Revision : 1.0
// ============================================================================
package stb_cmd_pkg;

  localparam int STB_ADDR_W  = 32;
  localparam int STB_SMC_W   = 6;
  localparam int BYTE_STRB_W = 4;
  localparam int BRST_W      = 2;
  localparam int UR_ID_W     = 4;
  localparam int UR_ADDR_W   = 11;

  typedef struct packed {
    logic [STB_SMC_W-1:0]   smc_strb;
    logic [BYTE_STRB_W-1:0] byte_strb;
    logic [BRST_W-1:0]      brst;
    logic [STB_ADDR_W-1:0]  gr_base;
    logic [UR_ID_W-1:0]     ur_id;
    logic [UR_ADDR_W-1:0]   ur_addr;
  } stb_cmd_t;

  localparam int CMD_W = $bits(stb_cmd_t);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } stb_state_e;

  // Packed command width for non-default address / SMC widths.
  function automatic int cmd_width(input int addr_w, input int smc_w);
    return smc_w + BYTE_STRB_W + BRST_W + addr_w + UR_ID_W + UR_ADDR_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stb_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : stb_cmd_fifo
// Brief    : Synchronous command FIFO with wrap-bit pointers, level and flush.
// Revision : 1.0
// ============================================================================
module stb_cmd_fifo #(
  parameter int WIDTH = 59,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             w_push;
  logic             w_pop;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == FULL_LVL);
  assign empty_o = (level_o == '0);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Flush outranks both push and pop; a full queue never takes a write.
  assign w_push = push_i && !full_o && !flush_i;
  assign w_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/stb_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : stb_cmd_queue
// Brief    : Queues STB burst-store commands and issues them one at a time,
//            waiting for datapath completion with a timeout guard.
// Revision : 1.0
// ============================================================================
module stb_cmd_queue
  import stb_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int SMC_COUNT  = 6,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [SMC_COUNT-1:0]   cmd_smc_strb,
  input  logic [3:0]             cmd_byte_strb,
  input  logic [1:0]             cmd_brst,
  input  logic [ADDR_WIDTH-1:0]  cmd_gr_base,
  input  logic [3:0]             cmd_ur_id,
  input  logic [10:0]            cmd_ur_addr,
  input  logic                   flush,
  output logic                   stb_u_valid,
  output logic [SMC_COUNT-1:0]   stb_u_smc_strb,
  output logic [3:0]             stb_u_byte_strb,
  output logic [1:0]             stb_u_brst,
  output logic [ADDR_WIDTH-1:0]  stb_u_gr_base_addr,
  output logic [3:0]             stb_u_ur_id,
  output logic [10:0]            stb_u_ur_addr,
  input  logic                   stb_d_valid,
  input  logic                   stb_d_done,
  output logic                   stb_d_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [15:0]            done_cnt,
  output logic [7:0]             err_cnt
);

  localparam int CW    = cmd_width(ADDR_WIDTH, SMC_COUNT);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  stb_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CW-1:0]    u_cmd_q, u_cmd_d;
  logic             u_valid_q, u_valid_d;
  logic             tmo_err_q, tmo_err_d;
  logic [15:0]      done_cnt_q, done_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic [CW-1:0]    fifo_wdata, fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic             done_evt, tmo_evt;

  assign fifo_wdata = {cmd_smc_strb, cmd_byte_strb, cmd_brst,
                       cmd_gr_base, cmd_ur_id, cmd_ur_addr};
  assign cmd_ready  = !fifo_full && !flush && rst_n;

  stb_cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid && cmd_ready),
    .pop_i   (fifo_pop),
    .flush_i (flush),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    done_evt = 1'b0;
    tmo_evt  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && !flush) begin
          state_d  = ISSUE;
          fifo_pop = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Completion is checked first so it beats a coincident timeout.
        if (stb_d_valid && stb_d_done) begin
          state_d  = IDLE;
          done_evt = 1'b1;
        end else if (wait_cnt_q == TMO_LAST) begin
          state_d = IDLE;
          tmo_evt = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wait_cnt_d = (state_q == WAIT) ? wait_cnt_q + 1'b1 : '0;
    u_valid_d  = fifo_pop;
    u_cmd_d    = fifo_pop ? fifo_rdata : u_cmd_q;
    done_cnt_d = done_evt ? done_cnt_q + 16'd1 : done_cnt_q;
    err_cnt_d  = (tmo_evt && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    tmo_err_d  = tmo_err_q;
    if (flush)   tmo_err_d = 1'b0;
    if (tmo_evt) tmo_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      u_cmd_q    <= '0;
      u_valid_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      done_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      u_cmd_q    <= u_cmd_d;
      u_valid_q  <= u_valid_d;
      tmo_err_q  <= tmo_err_d;
      done_cnt_q <= done_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign {stb_u_smc_strb, stb_u_byte_strb, stb_u_brst,
          stb_u_gr_base_addr, stb_u_ur_id, stb_u_ur_addr} = u_cmd_q;

  assign stb_u_valid = u_valid_q;
  assign stb_d_ready = (state_q == WAIT);
  assign busy        = (state_q != IDLE);
  assign timeout_err = tmo_err_q;
  assign done_cnt    = done_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_stb_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_stb_cmd_queue
// Brief    : Directed vector bench for stb_cmd_queue (DEPTH=8, TIMEOUT=16).
// Revision : 1.0
// ============================================================================
module tb_stb_cmd_queue;
  import stb_cmd_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n, cmd_valid, cmd_ready, flush;
  logic [5:0]  cmd_smc_strb;
  logic [3:0]  cmd_byte_strb;
  logic [1:0]  cmd_brst;
  logic [31:0] cmd_gr_base;
  logic [3:0]  cmd_ur_id;
  logic [10:0] cmd_ur_addr;
  logic        stb_u_valid;
  logic [5:0]  stb_u_smc_strb;
  logic [3:0]  stb_u_byte_strb;
  logic [1:0]  stb_u_brst;
  logic [31:0] stb_u_gr_base_addr;
  logic [3:0]  stb_u_ur_id;
  logic [10:0] stb_u_ur_addr;
  logic        stb_d_valid, stb_d_done, stb_d_ready;
  logic [3:0]  level;
  logic        busy, timeout_err;
  logic [15:0] done_cnt;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  stb_cmd_queue #(
    .ADDR_WIDTH (32), .SMC_COUNT (6), .DEPTH (DEPTH), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .rst_n (rst_n), .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
    .cmd_smc_strb (cmd_smc_strb), .cmd_byte_strb (cmd_byte_strb), .cmd_brst (cmd_brst),
    .cmd_gr_base (cmd_gr_base), .cmd_ur_id (cmd_ur_id), .cmd_ur_addr (cmd_ur_addr),
    .flush (flush), .stb_u_valid (stb_u_valid), .stb_u_smc_strb (stb_u_smc_strb),
    .stb_u_byte_strb (stb_u_byte_strb), .stb_u_brst (stb_u_brst),
    .stb_u_gr_base_addr (stb_u_gr_base_addr), .stb_u_ur_id (stb_u_ur_id),
    .stb_u_ur_addr (stb_u_ur_addr), .stb_d_valid (stb_d_valid), .stb_d_done (stb_d_done),
    .stb_d_ready (stb_d_ready), .level (level), .busy (busy), .timeout_err (timeout_err),
    .done_cnt (done_cnt), .err_cnt (err_cnt)
  );

  typedef struct {
    int v, f, dv, dd, cmd;
    int uv, bsy, dr, rdy, lvl, done, err, te, icmd;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic stb_cmd_t mk_cmd(input int i);
    stb_cmd_t c;
    if (i == 0) begin
      c = '{smc_strb: 6'h3F, byte_strb: 4'hF, brst: 2'd2, gr_base: 32'h1000,
            ur_id: 4'd3, ur_addr: 11'h010};
    end else begin
      c.smc_strb  = 6'(i * 7 + 1);
      c.byte_strb = 4'(i);
      c.brst      = 2'(i);
      c.gr_base   = 32'h2000_0000 + 32'(i) * 32'h40;
      c.ur_id     = 4'(i + 5);
      c.ur_addr   = 11'(i * 37);
    end
    return c;
  endfunction

  function automatic logic [63:0] pk(input int uv, bsy, dr, rdy, te, lvl, done, err);
    return {24'd0, 1'(uv), 1'(bsy), 1'(dr), 1'(rdy), 1'(te), 3'd0,
            4'(lvl), 4'd0, 16'(done), 8'(err)};
  endfunction

  function automatic logic [63:0] obs();
    return pk(int'(stb_u_valid), int'(busy), int'(stb_d_ready), int'(cmd_ready),
              int'(timeout_err), int'(level), int'(done_cnt), int'(err_cnt));
  endfunction

  function automatic stb_cmd_t u_fields();
    stb_cmd_t c;
    c = '{smc_strb: stb_u_smc_strb, byte_strb: stb_u_byte_strb, brst: stb_u_brst,
          gr_base: stb_u_gr_base_addr, ur_id: stb_u_ur_id, ur_addr: stb_u_ur_addr};
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v, f, dv, dd, cmd);
    stb_cmd_t c;
    c = mk_cmd(cmd);
    cmd_valid     = 1'(v);
    flush         = 1'(f);
    stb_d_valid   = 1'(dv);
    stb_d_done    = 1'(dd);
    cmd_smc_strb  = c.smc_strb;
    cmd_byte_strb = c.byte_strb;
    cmd_brst      = c.brst;
    cmd_gr_base   = c.gr_base;
    cmd_ur_id     = c.ur_id;
    cmd_ur_addr   = c.ur_addr;
  endtask

  task automatic add(input int v, f, dv, dd, cmd, uv, bsy, dr, rdy, lvl, done, err, te, icmd);
    vec_t r;
    r = '{v: v, f: f, dv: dv, dd: dd, cmd: cmd, uv: uv, bsy: bsy, dr: dr, rdy: rdy,
          lvl: lvl, done: done, err: err, te: te, icmd: icmd};
    vecs.push_back(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gap, exp_done;

    // Expected outputs are sampled after the edge, with the row's inputs still applied.
    //   v f dv dd cmd | uv bsy dr rdy lvl done err te icmd
    add(1, 0, 0, 0, 0,   0, 0, 0, 1, 1, 0, 0, 0, -1);
    add(0, 0, 0, 0, 0,   1, 1, 0, 1, 0, 0, 0, 0,  0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, -1);
    add(0, 0, 1, 1, 0,   0, 0, 0, 1, 0, 1, 0, 0, -1);
    add(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 1, 0, 0, -1);
    // Flush with three queued and one in flight; the push alongside flush is dropped.
    add(1, 0, 0, 0, 1,   0, 0, 0, 1, 1, 1, 0, 0, -1);
    add(1, 0, 0, 0, 2,   1, 1, 0, 1, 1, 1, 0, 0,  1);
    add(1, 0, 0, 0, 3,   0, 1, 1, 1, 2, 1, 0, 0, -1);
    add(1, 0, 0, 0, 4,   0, 1, 1, 1, 3, 1, 0, 0, -1);
    add(1, 1, 0, 0, 5,   0, 1, 1, 0, 0, 1, 0, 0, -1);
    add(0, 0, 0, 0, 0,   0, 1, 1, 1, 0, 1, 0, 0, -1);
    add(0, 0, 1, 1, 0,   0, 0, 0, 1, 0, 2, 0, 0, -1);
    add(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 2, 0, 0, -1);
    add(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 2, 0, 0, -1);
    // Feedback outside WAIT is ignored; valid-without-done is ignored; done beats timeout.
    add(1, 0, 0, 0, 6,   0, 0, 0, 1, 1, 2, 0, 0, -1);
    add(0, 0, 1, 1, 0,   1, 1, 0, 1, 0, 2, 0, 0,  6);
    add(0, 0, 1, 1, 0,   0, 1, 1, 1, 0, 2, 0, 0, -1);
    for (int k = 0; k < TIMEOUT - 1; k++) add(0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 2, 0, 0, -1);
    add(0, 0, 1, 1, 0,   0, 0, 0, 1, 0, 3, 0, 0, -1);
    add(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 3, 0, 0, -1);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    check("reset_state", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    tick();
    check("post_reset", obs(), pk(0, 0, 0, 1, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].f, vecs[i].dv, vecs[i].dd, vecs[i].cmd);
      tick();
      check($sformatf("vec%0d", i), obs(),
            pk(vecs[i].uv, vecs[i].bsy, vecs[i].dr, vecs[i].rdy, vecs[i].te,
               vecs[i].lvl, vecs[i].done, vecs[i].err));
      if (vecs[i].icmd >= 0)
        check($sformatf("vec%0d_fields", i), 64'(u_fields()), 64'(mk_cmd(vecs[i].icmd)));
    end
    drive(0, 0, 0, 0, 0);

    // Timeout: WAIT lasts exactly TIMEOUT cycles, then the queued command issues.
    drive(1, 0, 0, 0, 7);
    tick();
    drive(1, 0, 0, 0, 8);
    tick();
    drive(0, 0, 0, 0, 0);
    check("tmo_issue", obs(), pk(1, 1, 0, 1, 0, 1, 3, 0));
    check("tmo_issue_fields", 64'(u_fields()), 64'(mk_cmd(7)));
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (stb_d_ready) n++;
      else break;
    end
    check("tmo_wait_len", 64'(n), 64'(TIMEOUT));
    check("tmo_after", obs(), pk(0, 0, 0, 1, 1, 1, 3, 1));
    tick();
    check("tmo_next_issue", obs(), pk(1, 1, 0, 1, 1, 0, 3, 1));
    check("tmo_next_fields", 64'(u_fields()), 64'(mk_cmd(8)));
    tick();
    drive(0, 0, 1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("tmo_next_done", obs(), pk(0, 0, 0, 1, 1, 0, 4, 1));

    // Fill: one in flight plus DEPTH queued, then a refused push, then in-order drain.
    for (int k = 0; k < DEPTH + 1; k++) begin
      drive(1, 0, 0, 0, 9 + k);
      tick();
    end
    check("fill_full", obs(), pk(0, 1, 1, 0, 1, DEPTH, 4, 1));
    drive(1, 0, 0, 0, 18);
    tick();
    check("fill_refused", obs(), pk(0, 1, 1, 0, 1, DEPTH, 4, 1));
    drive(0, 0, 0, 0, 0);
    exp_done = 4;
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i > 0) begin
        gap = 0;
        do begin
          tick();
          gap++;
        end while (!stb_u_valid && gap < 6);
        check($sformatf("drain%0d_gap", i), 64'(gap), 64'd1);
      end
      check($sformatf("drain%0d_fields", i), 64'(u_fields()), 64'(mk_cmd(9 + i)));
      if (i > 0) tick();
      drive(0, 0, 1, 1, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      exp_done++;
      check($sformatf("drain%0d_done", i), 64'(done_cnt), 64'(exp_done));
    end
    tick();
    tick();
    tick();
    check("drain_idle", obs(), pk(0, 0, 0, 1, 1, 0, 13, 1));

    // Reset asserted mid-WAIT with four commands queued.
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 0, k);
      tick();
    end
    check("pre_reset", obs(), pk(0, 1, 1, 1, 1, 4, 13, 1));
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    check("mid_reset", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    tick();
    check("reset_release", obs(), pk(0, 0, 0, 1, 0, 0, 0, 0));
    tick();
    check("reset_no_issue", obs(), pk(0, 0, 0, 1, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
